lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Round-robin arbiter that shares one 16-entry x 16-bit LIFO between NUM_REQ requesters. It sits between the requester ports and the LIFO control inputs (push, pop, data_in), and routes the popped value back to the winning requester with its ID. Requests are filtered against LIFO full and empty. A one-cycle recovery bubble follows every pop, so the LIFO's backup-top register is never read stale.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- DW, default 16: data width, must match LIFO.
- IDW, default $clog2(NUM_REQ): requester ID width.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_push  in  NUM_REQ  per-requester push request, held until granted.
- req_pop  in  NUM_REQ  per-requester pop request, held until granted; push+pop together = swap.
- req_data  in  NUM_REQ*DW  push data, slice i belongs to requester i.
- grant  out  NUM_REQ  one-hot combinational grant; request consumed this cycle.
- rsp_valid  out  1  pop/swap result valid for requester rsp_id.
- rsp_id  out  IDW  ID of requester owning rsp_data.
- rsp_data  out  DW  popped value; 0 when rsp_valid=0.
- lifo_push, lifo_pop  out  1  LIFO controls.
- lifo_din  out  DW  LIFO data_in.
- lifo_dout  in  DW  LIFO registered data_out.
- lifo_full, lifo_empty  in  1  LIFO flags.

## Operation
- Op per requester i:
  - push only: PUSH, eligible iff !lifo_full.
  - pop only: POP, eligible iff !lifo_empty.
  - both: SWAP, eligible iff !lifo_empty.
  - neither: not requesting.
- FSM, 2 states:
  - ARB: grant at most one eligible requester. Next state is COOL if the granted op is POP/SWAP, else stays ARB.
  - COOL: grant=0, lifo_push=lifo_pop=0. Always returns to ARB next cycle.
- Granting requester g drives:
  - lifo_push = PUSH|SWAP.
  - lifo_pop = POP|SWAP.
  - lifo_din = req_data[g]; lifo_din = 0 when no grant.
- Round-robin:
  - Search eligible requesters starting at rr_ptr, ascending with wrap.
  - On a grant to g, rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when no grant.
- Ineligible requesters are skipped, not blocked. A pop request while empty waits without stalling pushers.
- Response: for a POP/SWAP grant to g in cycle t, the next cycle has rsp_valid=1, rsp_id=g and rsp_data=lifo_dout.
- Requester contract: deassert the op in the cycle after grant, or re-present a new request. The arbiter does not buffer requests.

## Timing
- Reset values (rst high, asynchronous): state=ARB, rr_ptr=0, rsp_valid=0, rsp_id=0. Combinational outputs are forced 0 while rst=1.
- Grant latency: 0 cycles, same cycle as an eligible request in ARB.
- Pop-to-data latency: 1 cycle. rsp_valid coincides with the COOL cycle.
- Throughput:
  - Pushes: 1 per cycle.
  - Pops/swaps: 1 per 2 cycles.
- Full/empty are sampled combinationally in the grant cycle. Push-at-15-then-push: the second push waits because full rises after the first.
- Reset mid-operation: a pending response is dropped, state returns to ARB and rr_ptr returns to 0.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Configuration
- LIFO_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest-index eligible requester always wins and rr_ptr is not instantiated.
  - Undefined (default): round-robin as above.
  - All other behaviour is identical.

## Test plan
- Reset, then req_push=4'b0001 with data 0x00A1 for 1 cycle: grant=0001 and lifo_push=1 with lifo_din=0x00A1 in the same cycle; rr_ptr becomes 1.
- All four requesters push continuously from rr_ptr=0: grant sequence 0001,0010,0100,1000,0001 on consecutive cycles; the LIFO holds 16 entries and full rises. Further pushes get no grant while full.
- Push 0x1111 then 0x2222 by requester 0, then pop by requester 2: grant[2] at t, rsp_valid=1, rsp_id=2, rsp_data=0x2222 at t+1. No grant at t+1 even with requests pending.
- Empty LIFO, requester 1 pops and requester 3 pushes 0x0BEE: requester 3 is granted first. Requester 1 is granted on the next cycle and receives 0x0BEE one cycle later.
- Requester 0 swaps with 0x5555 while the LIFO holds 0x7777: lifo_push=lifo_pop=1; response is 0x7777 on rsp_id=0 and depth is unchanged.
- Assert rst in the cycle after a pop grant: rsp_valid=0 immediately. After release, the first grant again starts search at requester 0.

Source files
------------

// File: rtl/lifo_arbiter.sv
// Round-robin arbiter sharing one LIFO between NUM_REQ requesters, with a cool-down cycle after pops.
// Define LIFO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module lifo_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 16,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_push,
    input  logic [NUM_REQ-1:0]    req_pop,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  lifo_push,
    output logic                  lifo_pop,
    output logic [DW-1:0]         lifo_din,
    input  logic [DW-1:0]         lifo_dout,
    input  logic                  lifo_full,
    input  logic                  lifo_empty
);

    typedef enum logic {ARB = 1'b0, COOL = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] sel_oh;
    logic [IDW-1:0]     sel_id;
    logic [DW-1:0]      sel_data;
    logic               sel_push;
    logic               sel_pop;
    logic               found;
    logic               gnt_en;

`ifndef LIFO_ARB_FIXED_PRIO_EN
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    // Pop or swap needs data on the stack; a pure push needs room.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pop[i]) elig[i] = !lifo_empty;
            else            elig[i] = req_push[i] && !lifo_full;
        end
    end

    // Requesters at or above the pointer are searched before the wrapped ones.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef LIFO_ARB_FIXED_PRIO_EN
            upper[i] = 1'b1;
`else
            upper[i] = (i >= int'(rr_ptr_q));
`endif
        end
    end

    always_comb begin
        found    = 1'b0;
        sel_oh   = '0;
        sel_id   = '0;
        sel_data = '0;
        sel_push = 1'b0;
        sel_pop  = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && elig[i] && (upper[i] == (pass == 0))) begin
                    found     = 1'b1;
                    sel_oh[i] = 1'b1;
                    sel_id    = IDW'(i);
                    sel_data  = req_data[i*DW +: DW];
                    sel_push  = req_push[i];
                    sel_pop   = req_pop[i];
                end
            end
        end
    end

    always_comb begin
        gnt_en    = found && (state_q == ARB) && !rst;
        grant     = gnt_en ? sel_oh : '0;
        lifo_push = gnt_en && sel_push;
        lifo_pop  = gnt_en && sel_pop;
        lifo_din  = gnt_en ? sel_data : '0;
        rsp_valid = rsp_valid_q;
        rsp_id    = rsp_id_q;
        rsp_data  = (rsp_valid_q && !rst) ? lifo_dout : '0;
    end

    always_comb begin
        state_d     = (gnt_en && sel_pop) ? COOL : ARB;
        rsp_valid_d = gnt_en && sel_pop;
        rsp_id_d    = rsp_valid_d ? sel_id : rsp_id_q;
`ifndef LIFO_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (gnt_en) begin
            if (int'(sel_id) == NUM_REQ - 1) rr_ptr_d = '0;
            else                             rr_ptr_d = sel_id + IDW'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
`ifndef LIFO_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter: cycle table with forced flags, then
// multi-cycle sequences against a small behavioural LIFO.
module tb_lifo_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_push, req_pop;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    grant;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            lifo_push, lifo_pop;
    logic [DW-1:0]   lifo_din, lifo_dout;
    logic            lifo_full, lifo_empty;

    logic            force_flags;
    logic            tbl_full, tbl_empty;
    logic [DW-1:0]   mem [16];
    int              cnt;
    logic [DW-1:0]   dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lifo_arbiter #(.NUM_REQ(N), .DW(DW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_push(req_push), .req_pop(req_pop), .req_data(req_data),
        .grant(grant),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din),
        .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty)
    );

    // Behavioural 16-deep LIFO with registered data_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 0;
            dout <= '0;
        end else if (lifo_push && lifo_pop) begin
            if (cnt > 0) begin
                dout         <= mem[cnt-1];
                mem[cnt-1]   <= lifo_din;
            end
        end else if (lifo_push) begin
            if (cnt < 16) begin
                mem[cnt] <= lifo_din;
                cnt      <= cnt + 1;
            end
        end else if (lifo_pop) begin
            if (cnt > 0) begin
                dout <= mem[cnt-1];
                cnt  <= cnt - 1;
            end
        end
    end

    assign lifo_full  = force_flags ? tbl_full  : (cnt == 16);
    assign lifo_empty = force_flags ? tbl_empty : (cnt == 0);
    assign lifo_dout  = force_flags ? 16'hCAFE  : dout;

    typedef struct {
        logic [N-1:0]  push;
        logic [N-1:0]  pop;
        logic          full;
        logic          empty;
        logic [N-1:0]  grant;
        logic          lpush;
        logic          lpop;
        logic [DW-1:0] din;
        logic          rspv;
        logic [IDW-1:0] rspid;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_d(input int i, input logic [DW-1:0] v);
        req_data[i*DW +: DW] = v;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req_push = '1;
        req_pop  = '0;
        @(negedge clk);
        #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_lpush", 32'(lifo_push), 0);
        chk("rst_din", 32'(lifo_din), 0);
        chk("rst_rspv", 32'(rsp_valid), 0);
        chk("rst_rspid", 32'(rsp_id), 0);
        @(negedge clk);
        rst      = 1'b0;
        req_push = '0;
        req_pop  = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        force_flags = 1'b1;
        tbl_full    = 1'b0;
        tbl_empty   = 1'b1;
        req_push    = '0;
        req_pop     = '0;
        req_data    = '0;

        //           push     pop      f  e  grant    lp lo din       v  id
        tbl[0]  = '{4'b0001, 4'b0000, 0, 1, 4'b0001, 1, 0, 16'hD000, 0, 0};
        tbl[1]  = '{4'b0001, 4'b0000, 1, 1, 4'b0000, 0, 0, 16'h0000, 0, 0};
        tbl[2]  = '{4'b1111, 4'b0000, 0, 1, 4'b0010, 1, 0, 16'hD001, 0, 0};
        tbl[3]  = '{4'b1111, 4'b0000, 0, 1, 4'b0100, 1, 0, 16'hD002, 0, 0};
        tbl[4]  = '{4'b0011, 4'b0000, 0, 1, 4'b0001, 1, 0, 16'hD000, 0, 0};
        tbl[5]  = '{4'b0000, 4'b1000, 0, 1, 4'b0000, 0, 0, 16'h0000, 0, 0};
        tbl[6]  = '{4'b0000, 4'b1000, 0, 0, 4'b1000, 0, 1, 16'hD003, 0, 0};
        tbl[7]  = '{4'b0001, 4'b0000, 0, 0, 4'b0000, 0, 0, 16'h0000, 1, 3};
        tbl[8]  = '{4'b0100, 4'b0110, 1, 0, 4'b0010, 0, 1, 16'hD001, 0, 0};
        tbl[9]  = '{4'b0100, 4'b0100, 1, 0, 4'b0000, 0, 0, 16'h0000, 1, 1};
        tbl[10] = '{4'b0100, 4'b0100, 1, 0, 4'b0100, 1, 1, 16'hD002, 0, 0};
        tbl[11] = '{4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 16'h0000, 1, 2};
        tbl[12] = '{4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 16'h0000, 0, 0};

        for (int i = 0; i < N; i++) set_d(i, 16'hD000 + 16'(i));

        do_reset();
        for (int r = 0; r < 13; r++) begin
            req_push  = tbl[r].push;
            req_pop   = tbl[r].pop;
            tbl_full  = tbl[r].full;
            tbl_empty = tbl[r].empty;
            #1;
            chk($sformatf("t%0d_grant", r), 32'(grant), 32'(tbl[r].grant));
            chk($sformatf("t%0d_lpush", r), 32'(lifo_push), 32'(tbl[r].lpush));
            chk($sformatf("t%0d_lpop", r), 32'(lifo_pop), 32'(tbl[r].lpop));
            chk($sformatf("t%0d_din", r), 32'(lifo_din), 32'(tbl[r].din));
            chk($sformatf("t%0d_rspv", r), 32'(rsp_valid), 32'(tbl[r].rspv));
            chk($sformatf("t%0d_rdata", r), 32'(rsp_data),
                tbl[r].rspv ? 32'hCAFE : 32'h0);
            if (tbl[r].rspv)
                chk($sformatf("t%0d_rspid", r), 32'(rsp_id), 32'(tbl[r].rspid));
            step();
        end
        force_flags = 1'b0;

        // Single push right after reset, then pointer has advanced to 1.
        do_reset();
        set_d(0, 16'h00A1);
        req_push = 4'b0001;
        #1;
        chk("a_grant", 32'(grant), 32'h1);
        chk("a_lpush", 32'(lifo_push), 1);
        chk("a_din", 32'(lifo_din), 32'h00A1);
        step();
        req_push = 4'b0011;
        #1;
        chk("a_rr1", 32'(grant), 32'h2);
        step();

        // Continuous pushes from all four fill the LIFO.
        do_reset();
        for (int i = 0; i < N; i++) set_d(i, 16'h0A00 + 16'(i));
        req_push = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            #1;
            if (k < 16)
                chk($sformatf("b_grant%0d", k), 32'(grant), 32'(1 << (k % 4)));
            else begin
                chk("b_full_grant", 32'(grant), 0);
                chk("b_full_lpush", 32'(lifo_push), 0);
            end
            step();
        end

        // Push two values, pop by requester 2; pending request held off in COOL.
        do_reset();
        req_push = 4'b0001;
        set_d(0, 16'h1111);
        #1; chk("c_p1", 32'(grant), 32'h1); step();
        set_d(0, 16'h2222);
        #1; chk("c_p2", 32'(grant), 32'h1); step();
        req_push = 4'b0000;
        req_pop  = 4'b0100;
        #1;
        chk("c_pop_grant", 32'(grant), 32'h4);
        chk("c_pop_lpop", 32'(lifo_pop), 1);
        step();
        req_pop  = 4'b0000;
        req_push = 4'b0001;
        set_d(0, 16'h3333);
        #1;
        chk("c_cool_grant", 32'(grant), 0);
        chk("c_rspv", 32'(rsp_valid), 1);
        chk("c_rspid", 32'(rsp_id), 2);
        chk("c_rdata", 32'(rsp_data), 32'h2222);
        step();
        #1;
        chk("c_after_cool", 32'(grant), 32'h1);
        step();

        // Pop while empty is skipped; the pusher goes first.
        do_reset();
        req_pop  = 4'b0010;
        req_push = 4'b1000;
        set_d(3, 16'h0BEE);
        #1;
        chk("d_grant_push", 32'(grant), 32'h8);
        chk("d_lpop0", 32'(lifo_pop), 0);
        step();
        req_push = 4'b0000;
        #1;
        chk("d_grant_pop", 32'(grant), 32'h2);
        step();
        req_pop = 4'b0000;
        #1;
        chk("d_rspv", 32'(rsp_valid), 1);
        chk("d_rspid", 32'(rsp_id), 1);
        chk("d_rdata", 32'(rsp_data), 32'h0BEE);
        step();

        // Swap returns old top and leaves the new value on the stack.
        do_reset();
        req_push = 4'b0001;
        set_d(0, 16'h7777);
        #1; chk("e_push", 32'(grant), 32'h1); step();
        req_pop = 4'b0001;
        set_d(0, 16'h5555);
        #1;
        chk("e_swap_grant", 32'(grant), 32'h1);
        chk("e_swap_lpush", 32'(lifo_push), 1);
        chk("e_swap_lpop", 32'(lifo_pop), 1);
        chk("e_swap_din", 32'(lifo_din), 32'h5555);
        step();
        req_push = 4'b0000;
        req_pop  = 4'b0000;
        #1;
        chk("e_rspv", 32'(rsp_valid), 1);
        chk("e_rspid", 32'(rsp_id), 0);
        chk("e_rdata", 32'(rsp_data), 32'h7777);
        step();
        req_pop = 4'b0001;
        #1;
        chk("e_pop_lpush", 32'(lifo_push), 0);
        chk("e_pop_grant", 32'(grant), 32'h1);
        step();
        req_pop = 4'b0000;
        #1;
        chk("e_rdata2", 32'(rsp_data), 32'h5555);
        step();

        // Reset right after a pop grant drops the response and the pointer.
        do_reset();
        req_push = 4'b0100;
        set_d(2, 16'h4242);
        #1; chk("f_push", 32'(grant), 32'h4); step();
        req_push = 4'b0000;
        req_pop  = 4'b0100;
        #1; chk("f_pop", 32'(grant), 32'h4); step();
        req_pop = 4'b0000;
        rst     = 1'b1;
        #1;
        chk("f_rst_rspv", 32'(rsp_valid), 0);
        chk("f_rst_rdata", 32'(rsp_data), 0);
        step();
        rst      = 1'b0;
        req_push = 4'b1001;
        #1;
        chk("f_rr0", 32'(grant), 32'h1);
        step();
        req_push = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
